// File: rtl/stage_if_pkg.sv
// rtl/stage_if_pkg.sv - shared constants and fetch FSM encoding for stage_if
package stage_if_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_KILL  = 3'd4
  } if_state_e;

endpackage

// File: rtl/stage_if_if.sv
// rtl/stage_if_if.sv - instruction-memory request/grant/response port
// master = fetch stage, slave = instruction memory.
interface stage_if_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
) ();

  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INST_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/stage_if_if_id_reg.sv
// rtl/stage_if_if_id_reg.sv - IF/ID pipeline register with load/hold/flush
// Priority: flush > hold > load; anything else loads a bubble.
module if_id_reg
  import stage_if_pkg::*;
#(
  parameter int PC_WIDTH       = 32,
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic                      hold,
  input  logic                      flush,
  input  logic [PC_WIDTH-1:0]       pc_in,
  input  logic [INST_WIDTH-1:0]     inst_in,
  output logic [PC_WIDTH-1:0]       pc,
  output logic [INST_WIDTH-1:0]     inst,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic                      valid
);

  localparam logic [INST_WIDTH-1:0] BUBBLE_INST = INST_WIDTH'(NOP_INST);

  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic [INST_WIDTH-1:0]     inst_q, inst_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic                      valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush || (!hold && !load)) begin
      pc_d    = '0;
      inst_d  = BUBBLE_INST;
      valid_d = 1'b0;
    end else if (!hold) begin
      pc_d    = pc_in;
      inst_d  = inst_in;
      valid_d = 1'b1;
    end
    // Register-file addresses are pre-decoded so ID can start its read early.
    rs1_d = inst_d[15 +: REG_ADDR_WIDTH];
    rs2_d = inst_d[20 +: REG_ADDR_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      inst_q  <= BUBBLE_INST;
      rs1_q   <= '0;
      rs2_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      valid_q <= valid_d;
    end
  end

  assign pc    = pc_q;
  assign inst  = inst_q;
  assign rs1   = rs1_q;
  assign rs2   = rs2_q;
  assign valid = valid_q;

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - RISC-V instruction-fetch stage feeding the IF/ID register
// Optional memory-latency bubble counter enabled by defining IF_BUBBLE_CNT_EN.
module stage_if
  import stage_if_pkg::*;
#(
  parameter int                  PC_WIDTH       = 32,
  parameter int                  INST_WIDTH     = 32,
  parameter int                  REG_ADDR_WIDTH = 5,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic                      pc_sel,
  input  logic [PC_WIDTH-1:0]       pc_imm,
  stage_if_if.master                imem,
  output logic [PC_WIDTH-1:0]       IF_ID_pc,
  output logic [INST_WIDTH-1:0]     IF_ID_inst,
  output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  output logic                      IF_ID_valid,
  output logic [31:0]               bubble_cnt
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  if_state_e             state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [INST_WIDTH-1:0] hold_buf_q, hold_buf_d;

  logic [PC_WIDTH-1:0]   fetch_pc_inc;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  consume;
  logic                  issue_hold;
  logic                  ifid_load;
  logic [INST_WIDTH-1:0] ifid_inst;

  assign fetch_pc_inc = fetch_pc_q + PC_WIDTH'(4);
  assign redirect_pc  = pc_imm & ALIGN_MASK;
  assign consume      = (state_q == S_WAIT) && imem.imem_rvalid && !stall && !pc_sel;
  assign issue_hold   = (state_q == S_HOLD) && !stall && !pc_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RESET;
      fetch_pc_q <= RESET_PC & ALIGN_MASK;
      hold_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      hold_buf_q <= hold_buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    hold_buf_d = hold_buf_q;
    if (pc_sel) begin
      // A request already granted but not yet answered must have its response discarded.
      fetch_pc_d = redirect_pc;
      state_d    = S_REQ;
      if (((state_q == S_REQ) && imem.imem_gnt) ||
          ((state_q == S_WAIT) && !imem.imem_rvalid)) begin
        state_d = S_KILL;
      end
    end else begin
      case (state_q)
        S_RESET: state_d = S_REQ;
        S_REQ: begin
          if (imem.imem_gnt) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (stall) begin
              hold_buf_d = imem.imem_rdata;
              state_d    = S_HOLD;
            end else begin
              fetch_pc_d = fetch_pc_inc;
              state_d    = imem.imem_gnt ? S_WAIT : S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            fetch_pc_d = fetch_pc_inc;
            state_d    = S_REQ;
          end
        end
        S_KILL: begin
          if (imem.imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_RESET;
      endcase
    end
  end

  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = fetch_pc_q;
    case (state_q)
      S_REQ: imem.imem_req = 1'b1;
      S_WAIT: begin
        // Back-to-back issue on consume keeps a zero-wait memory at one instruction per cycle.
        if (consume) begin
          imem.imem_req  = 1'b1;
          imem.imem_addr = fetch_pc_inc;
        end
      end
      default: imem.imem_req = 1'b0;
    endcase
  end

  assign ifid_load = consume || issue_hold;
  assign ifid_inst = (state_q == S_HOLD) ? hold_buf_q : imem.imem_rdata;

  if_id_reg #(
    .PC_WIDTH      (PC_WIDTH),
    .INST_WIDTH    (INST_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_if_id_reg (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (ifid_load),
    .hold   (stall),
    .flush  (pc_sel),
    .pc_in  (fetch_pc_q),
    .inst_in(ifid_inst),
    .pc     (IF_ID_pc),
    .inst   (IF_ID_inst),
    .rs1    (IF_ID_rs1),
    .rs2    (IF_ID_rs2),
    .valid  (IF_ID_valid)
  );

`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!stall && !pc_sel && !ifid_load && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bubble_cnt_q <= '0;
    else          bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - self-checking bench for stage_if against a flag-based fetch model
module tb_stage_if;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] pc_imm = '0;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic        IF_ID_valid;
  logic [31:0] bubble_cnt;

  stage_if_if #(.PC_WIDTH(32), .INST_WIDTH(32)) imem ();

  stage_if dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .pc_sel     (pc_sel),
    .pc_imm     (pc_imm),
    .imem       (imem),
    .IF_ID_pc   (IF_ID_pc),
    .IF_ID_inst (IF_ID_inst),
    .IF_ID_rs1  (IF_ID_rs1),
    .IF_ID_rs2  (IF_ID_rs2),
    .IF_ID_valid(IF_ID_valid),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // model: which phase the fetcher is in, expressed as independent flags
  bit          m_boot, m_out, m_kill, m_held;
  logic [31:0] m_pc, m_hbuf, m_bcnt;
  logic [31:0] e_pc, e_inst;
  bit          e_valid;

  // memory and stimulus knobs
  logic [31:0] mq_data[$];
  int          mq_due[$];
  logic [31:0] acc_log[$];
  int          gnt_pct = 100, lat_min = 1, lat_max = 1, stall_pct = 0, sel_pct = 0;
  bit          f_stall = 0, f_sel = 0, ovr_en = 0;
  logic [31:0] f_imm = '0, ovr_data = '0, ovr_addr = '0;
  bit          last_req;
  logic [31:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_boot = 1; m_out = 0; m_kill = 0; m_held = 0;
    m_pc = 32'h0; m_hbuf = '0; m_bcnt = '0;
    e_pc = '0; e_inst = NOP; e_valid = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall = 0; pc_sel = 0;
    imem.imem_gnt = 0; imem.imem_rvalid = 0;
    #1;
    chk("rst_pc", IF_ID_pc, 32'h0);
    chk("rst_inst", IF_ID_inst, NOP);
    chk("rst_valid", IF_ID_valid, 0);
    chk("rst_rs1", IF_ID_rs1, 0);
    chk("rst_rs2", IF_ID_rs2, 0);
    chk("rst_req", imem.imem_req, 0);
    chk("rst_bcnt", bubble_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    // anything still in flight comes back late, during the first cycle(s) after reset
    foreach (mq_due[i]) mq_due[i] = cyc;
  endtask

  task automatic cycle();
    bit s, p, g, rv, take, req_phase, exp_req, nk;
    logic [31:0] imm, rd, exp_addr;

    chk("IF_ID_pc", IF_ID_pc, e_pc);
    chk("IF_ID_inst", IF_ID_inst, e_inst);
    chk("IF_ID_rs1", IF_ID_rs1, {27'b0, e_inst[19:15]});
    chk("IF_ID_rs2", IF_ID_rs2, {27'b0, e_inst[24:20]});
    chk("IF_ID_valid", IF_ID_valid, e_valid);
`ifdef IF_BUBBLE_CNT_EN
    chk("bubble_cnt", bubble_cnt, m_bcnt);
`else
    chk("bubble_cnt", bubble_cnt, 32'h0);
`endif

    s   = f_stall || ($urandom_range(99) < stall_pct);
    p   = f_sel || ($urandom_range(99) < sel_pct);
    imm = f_sel ? f_imm : $urandom();
    g   = $urandom_range(99) < gnt_pct;
    rv  = (mq_due.size() > 0) && (mq_due[0] <= cyc);
    rd  = rv ? mq_data[0] : $urandom();
    stall = s; pc_sel = p; pc_imm = imm;
    imem.imem_gnt = g; imem.imem_rvalid = rv; imem.imem_rdata = rd;
    #1;

    req_phase = !m_boot && !m_out && !m_kill && !m_held;
    take      = m_out && rv && !s && !p;
    exp_req   = req_phase || take;
    exp_addr  = take ? m_pc + 32'd4 : m_pc;
    chk("imem_req", imem.imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem.imem_addr, exp_addr);
    last_req  = imem.imem_req;
    last_addr = imem.imem_addr;

    if (rv) begin
      void'(mq_data.pop_front());
      void'(mq_due.pop_front());
    end
    if (imem.imem_req && g) begin
      if (ovr_en) begin
        mq_data.push_back(ovr_data);
        ovr_addr = imem.imem_addr;
        ovr_en = 0;
      end else begin
        mq_data.push_back($urandom());
      end
      mq_due.push_back(cyc + $urandom_range(lat_max, lat_min));
      acc_log.push_back(imem.imem_addr);
    end

    if (p) begin
      e_pc = '0; e_inst = NOP; e_valid = 0;
    end else if (s) begin
    end else if (take) begin
      e_pc = m_pc; e_inst = rd; e_valid = 1;
    end else if (m_held) begin
      e_pc = m_pc; e_inst = m_hbuf; e_valid = 1;
    end else begin
      e_pc = '0; e_inst = NOP; e_valid = 0;
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
    end

    if (p) begin
      nk = (req_phase && g) || (m_out && !rv);
      m_pc = imm & ~32'd3;
      m_boot = 0; m_out = 0; m_held = 0; m_kill = nk;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (req_phase) begin
      m_out = g;
    end else if (m_out) begin
      if (rv) begin
        m_out = 0;
        if (s) begin
          m_held = 1; m_hbuf = rd;
        end else begin
          m_pc = m_pc + 32'd4; m_out = g;
        end
      end
    end else if (m_held) begin
      if (!s) begin
        m_held = 0; m_pc = m_pc + 32'd4;
      end
    end else if (m_kill) begin
      if (rv) m_kill = 0;
    end

    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] seen[$];
    logic [31:0] bc_base;
    bit found;

    imem.imem_gnt = 0; imem.imem_rvalid = 0; imem.imem_rdata = '0;
    @(negedge clk);
    do_reset();

    // zero-wait memory streams 0,4,8,...
    acc_log.delete();
    repeat (8) begin
      cycle();
      if (IF_ID_valid && seen.size() < 3) seen.push_back(IF_ID_pc);
    end
    chk("t1_acc_n", acc_log.size() >= 3, 1);
    chk("t1_acc0", acc_log[0], 32'h0);
    chk("t1_acc1", acc_log[1], 32'h4);
    chk("t1_acc2", acc_log[2], 32'h8);
    chk("t1_seen_n", seen.size(), 3);
    chk("t1_seen0", seen[0], 32'h0);
    chk("t1_seen1", seen[1], 32'h4);
    chk("t1_seen2", seen[2], 32'h8);

    // response arrives under a 3-cycle stall and is issued afterwards without refetch
    ovr_en = 1; ovr_data = 32'h0050_0093;
    cycle();
    chk("t2_ovr_addr", ovr_addr, 32'h1C);
    f_stall = 1;
    repeat (3) cycle();
    f_stall = 0;
    cycle();
    chk("t2_inst", IF_ID_inst, 32'h0050_0093);
    chk("t2_pc", IF_ID_pc, 32'h1C);
    chk("t2_rs1", IF_ID_rs1, 0);
    chk("t2_rs2", IF_ID_rs2, 5);
    chk("t2_valid", IF_ID_valid, 1);
    cycle();
    chk("t2_next_acc", acc_log[$], 32'h20);

    // redirect while waiting: late response dropped, next fetch at 0x100
    lat_min = 3; lat_max = 3;
    cycle();
    lat_min = 1; lat_max = 1;
    f_sel = 1; f_imm = 32'h102;
    cycle();
    f_sel = 0;
    chk("t3_valid", IF_ID_valid, 0);
    chk("t3_inst", IF_ID_inst, NOP);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      found = last_req;
    end
    chk("t3_req_seen", found, 1);
    chk("t3_addr", last_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      found = IF_ID_valid;
    end
    chk("t3_valid_seen", found, 1);
    chk("t3_first_pc", IF_ID_pc, 32'h100);

    // grant withheld: request and address stay put, IF/ID fills with bubbles
    bc_base = m_bcnt;
    gnt_pct = 0;
    repeat (5) begin
      cycle();
      chk("t4_req", last_req, 1);
      chk("t4_addr", last_addr, 32'h108);
    end
    chk("t4_valid", IF_ID_valid, 0);
`ifdef IF_BUBBLE_CNT_EN
    chk("t4_bubbles", bubble_cnt, bc_base + 32'd4);
`endif

    // reset in the middle of a wait
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    cycle();
    cycle();
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle();
    chk("t5_boot_req", last_req, 0);
    cycle();
    chk("t5_req", last_req, 1);
    chk("t5_addr", last_addr, 32'h0);
    cycle();

    // top-of-address-space wrap
    acc_log.delete();
    f_sel = 1; f_imm = 32'hFFFF_FFFC;
    cycle();
    f_sel = 0;
    cycle();
    cycle();
    chk("t6_acc_n", acc_log.size(), 2);
    chk("t6_acc0", acc_log[0], 32'hFFFF_FFFC);
    chk("t6_acc1", acc_log[1], 32'h0);
    chk("t6_pc", IF_ID_pc, 32'hFFFF_FFFC);

    // randomized traffic
    stall_pct = 25; sel_pct = 4; gnt_pct = 60; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) < 3) do_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
